drum_hit_detector: RTL and testbench

- Multi-channel drum-pad front end placed after the PmodAD1 sample capture.
- Per channel: calibrates a resting baseline by averaging, reports live above-baseline intensity, and detects discrete hits.
- A hit is one pulse carrying the peak intensity, followed by a retrigger holdoff.
- Consumers are the game scoring and sound logic; they need one event per strike, not a continuous level.

---
 rtl/drum_pkg.sv | 31 +++
 rtl/drum_hit_channel.sv | 149 ++++++++++++++
 rtl/drum_hit_detector.sv | 63 ++++++
 tb/tb_drum_hit_detector.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : drum_pkg
// Brief    : Shared channel state encoding, default constants and level
//            saturation helper for the drum-pad hit detector.
// Revision : 1.0
// ----------------------------------------------------------------------------
package drum_pkg;

    localparam int MIN_DELTA = 5;
    localparam int LEVEL_W   = 7;
    localparam int CAL_LOG2  = 3;

    typedef enum logic [2:0] {
        ST_CAL     = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ATTACK  = 3'd2,
        ST_REPORT  = 3'd3,
        ST_HOLDOFF = 3'd4,
        ST_REARM   = 3'd5
    } state_t;

    // Clamp x to the largest value representable in w bits.
    function automatic logic [31:0] sat_level(input logic [31:0] x, input int w);
        logic [31:0] lim;
        lim = (32'd1 << w) - 32'd1;
        return (x > lim) ? lim : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/drum_hit_channel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : drum_hit_channel
// Brief    : One sensor channel: baseline calibration, live level and
//            peak-hold hit detection with retrigger holdoff.
// Revision : 1.0
// ----------------------------------------------------------------------------
module drum_hit_channel #(
    parameter int SW          = 8,
    parameter int LEVEL_W     = drum_pkg::LEVEL_W,
    parameter int MIN_DELTA   = drum_pkg::MIN_DELTA,
    parameter int CAL_LOG2    = drum_pkg::CAL_LOG2,
    parameter int HOLDOFF_SMP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_calibrate,
    input  logic               i_valid,
    input  logic [SW-1:0]      i_sample,
    output logic               o_busy,
    output logic               o_indicator,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_hit_valid,
    output logic [LEVEL_W-1:0] o_hit_level
);
    import drum_pkg::*;

    localparam int ACC_W = SW + CAL_LOG2;
    localparam int HW    = $clog2(HOLDOFF_SMP + 2);
    localparam logic [CAL_LOG2:0] c_CAL_LAST  = (CAL_LOG2+1)'((1 << CAL_LOG2) - 1);
    localparam logic [HW-1:0]     c_HOLD_INIT = HW'(HOLDOFF_SMP);

    state_t               r_state, w_state_nxt;
    logic [SW-1:0]        r_thr;
    logic [ACC_W-1:0]     r_acc;
    logic [CAL_LOG2:0]    r_cnt;
    logic [SW-1:0]        r_peak, w_peak_nxt;
    logic [HW-1:0]        r_hold, w_hold_nxt;
    logic                 r_ind;
    logic [LEVEL_W-1:0]   r_level;
    logic                 r_hit_valid;
    logic [LEVEL_W-1:0]   r_hit_level;

    logic [SW-1:0]        w_delta;
    logic                 w_above;
    logic [LEVEL_W-1:0]   w_level;
    logic [LEVEL_W-1:0]   w_peak_level;
    logic [ACC_W-1:0]     w_acc_sum;
    logic                 w_report;

    assign w_delta      = (i_sample > r_thr) ? (i_sample - r_thr) : '0;
    assign w_above      = (32'(w_delta) > MIN_DELTA);
    assign w_level      = LEVEL_W'(sat_level(32'(w_delta), LEVEL_W));
    assign w_peak_level = LEVEL_W'(sat_level(32'(r_peak), LEVEL_W));
    assign w_acc_sum    = r_acc + ACC_W'(i_sample);
    // A calibrate pulse landing in the report cycle suppresses that hit.
    assign w_report     = (r_state == ST_REPORT) && !i_calibrate;

    always_comb begin
        w_state_nxt = r_state;
        w_peak_nxt  = r_peak;
        w_hold_nxt  = r_hold;
        if (i_calibrate) begin
            w_state_nxt = ST_CAL;
        end else begin
            case (r_state)
                ST_CAL: begin
                    if (i_valid && (r_cnt == c_CAL_LAST)) w_state_nxt = ST_IDLE;
                end
                ST_IDLE: begin
                    if (i_valid && w_above) begin
                        w_state_nxt = ST_ATTACK;
                        w_peak_nxt  = w_delta;
                    end
                end
                ST_ATTACK: begin
                    if (i_valid) begin
                        if (w_above && (w_delta >= r_peak)) w_peak_nxt  = w_delta;
                        else                                w_state_nxt = ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    w_hold_nxt  = c_HOLD_INIT;
                    w_state_nxt = ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (i_valid) begin
                        if (r_hold <= HW'(1)) begin
                            w_hold_nxt  = '0;
                            w_state_nxt = ST_REARM;
                        end else begin
                            w_hold_nxt  = r_hold - HW'(1);
                        end
                    end
                end
                ST_REARM: begin
                    if (i_valid && !w_above) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_thr       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_peak      <= '0;
            r_hold      <= '0;
            r_ind       <= 1'b0;
            r_level     <= '0;
            r_hit_valid <= 1'b0;
            r_hit_level <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_peak      <= w_peak_nxt;
            r_hold      <= w_hold_nxt;
            r_hit_valid <= w_report;
            r_hit_level <= w_report ? w_peak_level : '0;
            if (i_calibrate) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_ind   <= 1'b0;
                r_level <= '0;
            end else if (r_state == ST_CAL) begin
                r_ind   <= 1'b0;
                r_level <= '0;
                if (i_valid) begin
                    r_acc <= w_acc_sum;
                    r_cnt <= r_cnt + (CAL_LOG2+1)'(1);
                    if (r_cnt == c_CAL_LAST) r_thr <= SW'(w_acc_sum >> CAL_LOG2);
                end
            end else if (i_valid) begin
                r_ind   <= w_above;
                r_level <= w_above ? w_level : '0;
            end
        end
    end

    assign o_busy      = (r_state == ST_CAL);
    assign o_indicator = r_ind;
    assign o_level     = r_level;
    assign o_hit_valid = r_hit_valid;
    assign o_hit_level = r_hit_level;

endmodule
`default_nettype wire

// File: rtl/drum_hit_detector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : drum_hit_detector
// Brief    : Multi-channel drum-pad front end; one independent hit detector
//            per ADC channel, with a shared calibration busy flag.
// Revision : 1.0
// ----------------------------------------------------------------------------
module drum_hit_detector #(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 16,
    parameter int SMP_MSB     = 9,
    parameter int SMP_LSB     = 2,
    parameter int LEVEL_W     = drum_pkg::LEVEL_W,
    parameter int MIN_DELTA   = drum_pkg::MIN_DELTA,
    parameter int CAL_LOG2    = drum_pkg::CAL_LOG2,
    parameter int HOLDOFF_SMP = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      calibrate,
    input  logic                      data_valid,
    input  logic [NUM_CH*DATA_W-1:0]  data_in,
    output logic                      cal_busy,
    output logic [NUM_CH-1:0]         sound_indicator,
    output logic [NUM_CH*LEVEL_W-1:0] sound_level,
    output logic [NUM_CH-1:0]         hit_valid,
    output logic [NUM_CH*LEVEL_W-1:0] hit_level
);
    import drum_pkg::*;

    localparam int SW = SMP_MSB - SMP_LSB + 1;

    logic [NUM_CH-1:0] w_busy;
    // Bits outside the sample field are don't-care padding from the ADC.
    logic              w_unused_bits;

    assign w_unused_bits = ^data_in;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        drum_hit_channel #(
            .SW          (SW),
            .LEVEL_W     (LEVEL_W),
            .MIN_DELTA   (MIN_DELTA),
            .CAL_LOG2    (CAL_LOG2),
            .HOLDOFF_SMP (HOLDOFF_SMP)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_calibrate (calibrate),
            .i_valid     (data_valid),
            .i_sample    (data_in[c*DATA_W+SMP_LSB +: SW]),
            .o_busy      (w_busy[c]),
            .o_indicator (sound_indicator[c]),
            .o_level     (sound_level[c*LEVEL_W +: LEVEL_W]),
            .o_hit_valid (hit_valid[c]),
            .o_hit_level (hit_level[c*LEVEL_W +: LEVEL_W])
        );
    end

    assign cal_busy = |w_busy;

endmodule
`default_nettype wire

// File: tb/tb_drum_hit_detector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_drum_hit_detector
// Brief    : Directed and randomized bench for drum_hit_detector against a
//            sample-level behavioural model.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_drum_hit_detector;

    localparam int NCH  = 2;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        calibrate;
    logic        data_valid;
    logic [31:0] data_in;
    logic        cal_busy;
    logic [1:0]  sound_indicator;
    logic [13:0] sound_level;
    logic [1:0]  hit_valid;
    logic [13:0] hit_level;

    drum_hit_detector dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .calibrate       (calibrate),
        .data_valid      (data_valid),
        .data_in         (data_in),
        .cal_busy        (cal_busy),
        .sound_indicator (sound_indicator),
        .sound_level     (sound_level),
        .hit_valid       (hit_valid),
        .hit_level       (hit_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: baseline, calibration progress, press/peak, holdoff and release.
    int m_thr[NCH], m_calleft[NCH], m_acc[NCH], m_peak[NCH], m_hold[NCH];
    bit m_press[NCH], m_wait[NCH], m_rep[NCH];
    int e_ind[NCH], e_lvl[NCH], e_hv[NCH], e_hl[NCH];
    int hits[NCH];
    logic [1:0] prev_hv = 2'b00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > 127) ? 127 : x;
    endfunction

    function automatic logic [15:0] word(input logic [7:0] f);
        logic [5:0] hi;
        logic [1:0] lo;
        hi = 6'($urandom);
        lo = 2'($urandom);
        return {hi, f, lo};
    endfunction

    task automatic model(input bit rst, input bit cal, input bit v, input int f0, input int f1);
        for (int c = 0; c < NCH; c++) begin
            int f, d;
            bit above, was_rep;
            f = (c == 0) ? f0 : f1;
            if (rst) begin
                m_thr[c] = 0; m_calleft[c] = 0; m_acc[c] = 0; m_peak[c] = 0; m_hold[c] = 0;
                m_press[c] = 0; m_wait[c] = 0; m_rep[c] = 0;
                e_ind[c] = 0; e_lvl[c] = 0; e_hv[c] = 0; e_hl[c] = 0;
                continue;
            end
            e_hv[c] = (m_rep[c] && !cal) ? 1 : 0;
            e_hl[c] = e_hv[c] ? sat(m_peak[c]) : 0;
            was_rep = m_rep[c];
            m_rep[c] = 0;
            if (was_rep) m_hold[c] = HOLD;
            if (cal) begin
                m_calleft[c] = 8; m_acc[c] = 0;
                m_press[c] = 0; m_hold[c] = 0; m_wait[c] = 0;
                e_ind[c] = 0; e_lvl[c] = 0;
            end else if (m_calleft[c] > 0) begin
                e_ind[c] = 0; e_lvl[c] = 0;
                if (v) begin
                    m_acc[c] += f;
                    m_calleft[c]--;
                    if (m_calleft[c] == 0) m_thr[c] = m_acc[c] / 8;
                end
            end else if (v) begin
                d = (f > m_thr[c]) ? f - m_thr[c] : 0;
                above = d > 5;
                e_ind[c] = above;
                e_lvl[c] = above ? sat(d) : 0;
                if (!was_rep) begin
                    if (m_hold[c] > 0) begin
                        m_hold[c]--;
                        if (m_hold[c] == 0) m_wait[c] = 1;
                    end else if (m_wait[c]) begin
                        if (!above) m_wait[c] = 0;
                    end else if (m_press[c]) begin
                        if (above && d >= m_peak[c]) m_peak[c] = d;
                        else begin m_press[c] = 0; m_rep[c] = 1; end
                    end else if (above) begin
                        m_press[c] = 1; m_peak[c] = d;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit cal, input bit v, input logic [7:0] f0, input logic [7:0] f1);
        int busy;
        rst_n      = !rst;
        calibrate  = cal;
        data_valid = v;
        data_in    = {word(f1), word(f0)};
        @(posedge clk);
        model(rst, cal, v, int'(f0), int'(f1));
        #1;
        busy = (m_calleft[0] > 0 || m_calleft[1] > 0) ? 1 : 0;
        chk("cal_busy", 32'(cal_busy), 32'(busy));
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("ind%0d", c), 32'(sound_indicator[c]), 32'(e_ind[c]));
            chk($sformatf("lvl%0d", c), 32'(sound_level[c*7 +: 7]), 32'(e_lvl[c]));
            chk($sformatf("hv%0d", c), 32'(hit_valid[c]), 32'(e_hv[c]));
            if (e_hv[c] != 0 || rst)
                chk($sformatf("hl%0d", c), 32'(hit_level[c*7 +: 7]), 32'(e_hl[c]));
            chk($sformatf("hv_twice%0d", c), 32'(hit_valid[c] & prev_hv[c]), 32'd0);
            if (hit_valid[c]) hits[c]++;
        end
        prev_hv = hit_valid;
    endtask

    initial begin
        int h0, h1;
        logic [7:0] f3[6];
        int l3[6];
        f3 = '{8'd40, 8'd50, 8'd80, 8'd120, 8'd90, 8'd40};
        l3 = '{0, 10, 40, 80, 50, 0};
        hits = '{0, 0};
        rst_n = 1'b0; calibrate = 1'b0; data_valid = 1'b0; data_in = '0;

        // Reset and uncalibrated threshold of zero
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_flags", {27'd0, cal_busy, sound_indicator, hit_valid}, 32'd0);
        chk("rst_levels", {4'd0, sound_level, hit_level}, 32'd0);
        step(0, 0, 1, 3, 0);
        chk("s1_ind3", 32'(sound_indicator[0]), 32'd0);
        step(0, 0, 1, 6, 0);
        chk("s1_ind6", 32'(sound_indicator[0]), 32'd1);
        chk("s1_lvl6", 32'(sound_level[6:0]), 32'd6);
        repeat (8) step(0, 0, 1, 0, 0);

        // Calibration to a baseline of 40 on ch0
        step(0, 1, 0, 0, 0);
        chk("s2_busy_rise", 32'(cal_busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 40, 10);
            chk("s2_busy", 32'(cal_busy), (i < 7) ? 32'd1 : 32'd0);
        end
        step(0, 0, 1, 45, 10);
        chk("s2_ind45", 32'(sound_indicator[0]), 32'd0);
        step(0, 0, 1, 46, 10);
        chk("s2_ind46", 32'(sound_indicator[0]), 32'd1);
        chk("s2_lvl46", 32'(sound_level[6:0]), 32'd6);
        repeat (8) step(0, 0, 1, 40, 10);

        // Rising strike with peak 80 above baseline
        h0 = hits[0];
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, f3[i], 10);
            chk("s3_lvl", 32'(sound_level[6:0]), 32'(l3[i]));
        end
        chk("s3_hv", 32'(hit_valid[0]), 32'd1);
        chk("s3_hl", 32'(hit_level[6:0]), 32'd80);
        repeat (8) step(0, 0, 1, 40, 10);
        chk("s3_one_hit", 32'(hits[0] - h0), 32'd1);

        // Saturation on ch1 with zero baseline; ch0 quiet
        step(1, 0, 0, 0, 0);
        h0 = hits[0]; h1 = hits[1];
        step(0, 0, 1, 0, 255);
        chk("s4_lvl255", 32'(sound_level[13:7]), 32'd127);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("s4_hv", {30'd0, hit_valid}, 32'd2);
        chk("s4_hl", 32'(hit_level[13:7]), 32'd127);
        repeat (7) step(0, 0, 1, 0, 0);
        chk("s4_ch0_quiet", 32'(hits[0] - h0), 32'd0);
        chk("s4_ch1_one", 32'(hits[1] - h1), 32'd1);

        // Holdoff and sustained press block retriggers
        h0 = hits[0];
        step(0, 0, 1, 100, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("s5_first", 32'(hits[0] - h0), 32'd1);
        step(0, 0, 1, 120, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 120, 0);
        repeat (10) step(0, 0, 1, 100, 0);
        chk("s5_blocked", 32'(hits[0] - h0), 32'd1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 100, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("s5_second", 32'(hits[0] - h0), 32'd2);
        repeat (7) step(0, 0, 1, 0, 0);

        // Calibrate and reset both abort an attack
        h0 = hits[0];
        step(0, 0, 1, 100, 0);
        step(0, 1, 1, 0, 0);
        chk("s6_cal_busy", 32'(cal_busy), 32'd1);
        chk("s6_cal_lvl", 32'(sound_level[6:0]), 32'd0);
        repeat (8) step(0, 0, 1, 0, 0);
        chk("s6_cal_done", 32'(cal_busy), 32'd0);
        step(0, 0, 1, 100, 0);
        step(1, 0, 1, 0, 0);
        chk("s6_rst_lvl", {18'd0, sound_level}, 32'd0);
        repeat (6) step(0, 0, 1, 0, 0);
        chk("s6_no_hit", 32'(hits[0] - h0), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r0, r1;
            r0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
            r1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 7), r0, r1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
